// File: rtl/fd_pkg.sv
// Shared defaults and the {instr, pc} entry layout for the fetch->decode queue.
package fd_pkg;
  localparam int FD_INSTR_W = 32;
  localparam int FD_PC_W    = 32;
  localparam int FD_DEPTH   = 4;
  localparam logic [FD_INSTR_W-1:0] FD_NOP_INSTR = '0;

  typedef struct packed {
    logic [FD_INSTR_W-1:0] instr;
    logic [FD_PC_W-1:0]    pc;
  } fd_entry_t;
endpackage

// File: rtl/fd_queue_mem.sv
// Purpose: DEPTH x W register array, one write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller decides when wr_en may be asserted.
module fd_queue_mem #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fetch_decode_queue.sv
// Purpose: DEPTH-entry in-order {instr, pc} queue between fetch and decode, flushable.
// Latency: an entry enqueued in cycle N is presented on d_* in cycle N+1.
// Backpressure: registered f_stall when full; enq is refused while full even if decode drains.
module fetch_decode_queue
  import fd_pkg::*;
#(
  parameter int                   INSTR_W   = FD_INSTR_W,
  parameter int                   PC_W      = FD_PC_W,
  parameter int                   DEPTH     = FD_DEPTH,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(FD_NOP_INSTR),
  parameter int                   AW        = $clog2(DEPTH),
  parameter int                   CW        = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               f_valid,
  input  logic [INSTR_W-1:0] f_instr,
  input  logic [PC_W-1:0]    f_pc,
  input  logic               f_flush,
  output logic               f_stall,
  input  logic               d_stall,
  output logic               d_valid,
  output logic [INSTR_W-1:0] d_instr,
  output logic [PC_W-1:0]    d_pc,
  output logic [CW-1:0]      count
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  enq;
  logic                  deq;
  logic [INSTR_W+PC_W-1:0] rd_data;

  assign enq = f_valid & ~f_stall & ~f_flush;
  assign deq = ~d_stall & (count != '0) & ~f_flush;

  always_comb begin
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // f_stall is computed from next-state count so it is a clean flop output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      f_stall <= 1'b0;
    end else if (f_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      f_stall <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      f_stall <= (count_next == FULL_CNT);
    end
  end

  fd_queue_mem #(
    .W     (INSTR_W + PC_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (enq),
    .wr_addr (wr_ptr),
    .wr_data ({f_instr, f_pc}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign d_valid = (count != '0);
  assign d_instr = d_valid ? rd_data[INSTR_W+PC_W-1:PC_W] : NOP_INSTR;
  assign d_pc    = d_valid ? rd_data[PC_W-1:0] : '0;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed vector table plus hand sequences for async reset and random-stall wrap ordering.
module tb_fetch_decode_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_flush;
  logic        f_stall;
  logic        d_stall;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  fetch_decode_queue dut (
    .clock   (clock),
    .reset   (reset),
    .f_valid (f_valid),
    .f_instr (f_instr),
    .f_pc    (f_pc),
    .f_flush (f_flush),
    .f_stall (f_stall),
    .d_stall (d_stall),
    .d_valid (d_valid),
    .d_instr (d_instr),
    .d_pc    (d_pc),
    .count   (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        fl;
    logic        ds;
    logic        dv;
    logic [31:0] dpc;
    logic [2:0]  cnt;
    logic        fs;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic fv, input logic [31:0] pc, input logic fl,
                              input logic ds, input logic dv, input logic [31:0] dpc,
                              input logic [2:0] cnt, input logic fs);
    vec_t v;
    v.fv = fv; v.pc = pc; v.fl = fl; v.ds = ds;
    v.dv = dv; v.dpc = dpc; v.cnt = cnt; v.fs = fs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic fl, input logic ds);
    f_valid = fv;
    f_pc    = pc;
    f_instr = instr_of(pc);
    f_flush = fl;
    d_stall = ds;
  endtask

  logic [31:0] mq[$];
  int sent;
  int got;
  logic fv_r;
  logic ds_r;
  logic enq_m;
  logic deq_m;

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Idle/bubble, pass-through, fill/full/drain, flush on a full queue.
    vecs.push_back(mk(0, 32'h000, 0, 0, 0, 32'h000, 3'd0, 0));
    vecs.push_back(mk(0, 32'h000, 0, 0, 0, 32'h000, 3'd0, 0));
    vecs.push_back(mk(0, 32'h000, 0, 0, 0, 32'h000, 3'd0, 0));
    vecs.push_back(mk(1, 32'h000, 0, 0, 1, 32'h000, 3'd1, 0));
    vecs.push_back(mk(1, 32'h004, 0, 0, 1, 32'h004, 3'd1, 0));
    vecs.push_back(mk(1, 32'h008, 0, 0, 1, 32'h008, 3'd1, 0));
    vecs.push_back(mk(0, 32'h000, 0, 0, 0, 32'h000, 3'd0, 0));
    vecs.push_back(mk(1, 32'h010, 0, 1, 1, 32'h010, 3'd1, 0));
    vecs.push_back(mk(1, 32'h014, 0, 1, 1, 32'h010, 3'd2, 0));
    vecs.push_back(mk(1, 32'h018, 0, 1, 1, 32'h010, 3'd3, 0));
    vecs.push_back(mk(1, 32'h01C, 0, 1, 1, 32'h010, 3'd4, 1));
    vecs.push_back(mk(1, 32'h020, 0, 1, 1, 32'h010, 3'd4, 1));
    vecs.push_back(mk(1, 32'h020, 0, 0, 1, 32'h014, 3'd3, 0));
    vecs.push_back(mk(1, 32'h020, 0, 0, 1, 32'h018, 3'd3, 0));
    vecs.push_back(mk(0, 32'h000, 0, 0, 1, 32'h01C, 3'd2, 0));
    vecs.push_back(mk(0, 32'h000, 0, 0, 1, 32'h020, 3'd1, 0));
    vecs.push_back(mk(0, 32'h000, 0, 0, 0, 32'h000, 3'd0, 0));
    vecs.push_back(mk(1, 32'h030, 0, 1, 1, 32'h030, 3'd1, 0));
    vecs.push_back(mk(1, 32'h034, 0, 1, 1, 32'h030, 3'd2, 0));
    vecs.push_back(mk(1, 32'h038, 0, 1, 1, 32'h030, 3'd3, 0));
    vecs.push_back(mk(1, 32'h03C, 0, 1, 1, 32'h030, 3'd4, 1));
    vecs.push_back(mk(1, 32'h040, 1, 0, 0, 32'h000, 3'd0, 0));
    vecs.push_back(mk(1, 32'h100, 0, 1, 1, 32'h100, 3'd1, 0));
    vecs.push_back(mk(0, 32'h000, 0, 0, 0, 32'h000, 3'd0, 0));

    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dvalid", 32'(d_valid), 32'd0);
    chk("rst_fstall", 32'(f_stall), 32'd0);
    chk("rst_dinstr", d_instr, 32'h0);
    chk("rst_dpc", d_pc, 32'h0);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].fv, vecs[i].pc, vecs[i].fl, vecs[i].ds);
      tick();
      chk($sformatf("vec%0d_dvalid", i), 32'(d_valid), 32'(vecs[i].dv));
      chk($sformatf("vec%0d_dpc", i), d_pc, vecs[i].dpc);
      chk($sformatf("vec%0d_dinstr", i), d_instr,
          vecs[i].dv ? instr_of(vecs[i].dpc) : 32'h0);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_fstall", i), 32'(f_stall), 32'(vecs[i].fs));
    end

    // Asynchronous reset mid-stream: outputs clear before the next edge.
    drive(1'b1, 32'h200, 1'b0, 1'b1); tick();
    drive(1'b1, 32'h204, 1'b0, 1'b1); tick();
    drive(1'b1, 32'h208, 1'b0, 1'b1); tick();
    chk("mid_pre_count", 32'(count), 32'd3);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_dvalid", 32'(d_valid), 32'd0);
    chk("mid_rst_dinstr", d_instr, 32'h0);
    chk("mid_rst_dpc", d_pc, 32'h0);
    #2 reset = 1'b1;
    drive(1'b1, 32'h2A0, 1'b0, 1'b0); tick();
    chk("post_rst_dpc", d_pc, 32'h2A0);
    chk("post_rst_count", 32'(count), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
    chk("post_rst_drain", 32'(count), 32'd0);

    // Wrap: 10 entries through the queue under random decode stalls.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      fv_r = (sent < 10);
      ds_r = 1'($urandom_range(0, 1));
      drive(fv_r, 32'h300 + 32'(sent) * 32'd4, 1'b0, ds_r);
      chk("wrap_dvalid", 32'(d_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("wrap_pc", d_pc, mq[0]);
      enq_m = fv_r && (mq.size() != 4);
      deq_m = !ds_r && (mq.size() != 0);
      if (deq_m) begin
        void'(mq.pop_front());
        got++;
      end
      if (enq_m) begin
        mq.push_back(f_pc);
        sent++;
      end
      tick();
      chk("wrap_count", 32'(count), 32'(mq.size()));
      chk("wrap_fstall", 32'(f_stall), 32'(mq.size() == 4));
      chk("wrap_le_depth", 32'(count <= 3'd4), 32'd1);
    end
    chk("wrap_drained", 32'(got), 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
